bell_tone_decode_57: RTL and testbench
======================================

Name: bell_tone_decode_57

Overview:
- Receive-side counterpart of the buzzer tone path: takes the single-bit square wave driven to the buzzer and recovers which scale note (do..doh) is sounding, or silence.
- Sits on the 50 MHz domain, tapped from the bell output net.
- Used for on-board self-test of alarm and organ playback, and to drive a "note playing" indication on the display.

Parameters:
- P_DO, 190840, expected full period in clk cycles for do (262 Hz).
- P_RE, 170068, expected period for re (294 Hz).
- P_MI, 151515, expected period for mi (330 Hz).
- P_FA, 143266, expected period for fa (349 Hz).
- P_SO, 127551, expected period for so (392 Hz).
- P_LA, 113636, expected period for la (440 Hz).
- P_TI, 101215, expected period for ti (494 Hz).
- P_DOH, 95602, expected period for doh (523 Hz).
- TOL_SHIFT, 6, match window is ±(P_x >> TOL_SHIFT).
- MATCH_N, 3, consecutive same-class periods required to lock a note.
- SILENCE_CYC, 250000, cycles without a rising edge before silence is declared.

Ports:
- clk_50m_57  in  1  50 MHz system clock.
- rst_57  in  1  synchronous, active-low reset.
- bell_in_57  in  1  buzzer square wave (asynchronous to clk; synchronized internally).
- note_57  out  4  locked note: 0 = silence, 1..8 = do,re,mi,fa,so,la,ti,doh.
- note_chg_57  out  1  one-cycle pulse whenever note_57 changes value.
- period_57  out  20  last measured full period in clk cycles (saturating).
- err_57  out  1  sticky flag: a period matched no note while not silent; cleared only by reset.

Behaviour:
- Reset (rst_57 low at a clk edge): note_57=0, note_chg_57=0, period_57=0, err_57=0; counters, synchronizer and FSM cleared; state IDLE. Reset mid-measurement discards the partial period.
- Input path: 2-flop synchronizer plus 1 delay flop. Rising edge rise = s2 & ~s3. Edge-detect latency is 2–3 clk after the pin edge.
- Period counter cnt, 20 bits: increments every cycle, saturates at 2^20-1, cleared on rise.
- FSM states:
  - IDLE: ignore cnt. On rise go to ARM.
  - ARM: first edge seen, no valid period yet. On rise, period_57 <= cnt+1 (saturating) and go to MEAS. If cnt reaches SILENCE_CYC, go to IDLE.
  - MEAS: on each rise, period_57 <= cnt+1 and a classify is launched. If cnt reaches SILENCE_CYC, go to IDLE; if note_57 != 0, set note_57=0 and pulse note_chg_57.
- Classify (registered, cycle R+1 where R is the rise cycle): class = k if |period - P_k| <= (P_k >> TOL_SHIFT); else class = 15 (unknown). Windows are disjoint at defaults. Use 21-bit signed or ordered compares; no truncation.
- Lock (cycle R+2):
  - If class equals the previous class, run = min(run+1, MATCH_N); otherwise run = 1 and prev = class.
  - When run reaches MATCH_N with class in 1..8 and class != note_57: note_57 <= class, note_chg_57=1 in the same cycle.
  - Class 15 sets err_57 and resets run to 0; note_57 is held.
- A rise in the same cycle as the silence threshold: the rise wins (state stays MEAS/ARM, period captured).
- note_chg_57 never pulses twice on consecutive cycles. Outputs are registered only.
- Saturated period (2^20-1) classifies as unknown.

Optional Feature:
- Macro: BELL_TONE_DECODE_DUTY_EN.
- Defined:
  - A second counter measures high time per period.
  - A period is accepted for classify only if high time is between 3/8 and 5/8 of the period (compare 8*high against 3*period and 5*period).
  - Rejected periods count as class 15 and set err_57.
  - Adds output duty_err_57 (1 bit, sticky, reset 0).
- Not defined: duty is ignored; duty_err_57 is absent.

Test Plan:
- Reset: hold rst_57 low 5 cycles with toggling input -> note_57=0, period_57=0, err_57=0, no note_chg_57.
- Square wave period 113636 clk, 50% duty, 4 periods -> period_57=113636; note_57 goes 0→6 exactly 2 cycles after the 4th rise (3rd full period); single note_chg_57 pulse.
- mi (151515) locked, then switch to fa (143266) -> note_57 stays 3 for 2 fa periods, becomes 4 on the 3rd fa period with one note_chg_57 pulse.
- Tolerance: period 113636+1775 -> locks la; period 113636+1776 -> class unknown, err_57=1, note_57 unchanged.
- Silence: after la locked, hold input low -> note_57=0 with note_chg_57 exactly SILENCE_CYC cycles after the last rise; FSM in IDLE.
- Duty (macro on): period 95602 with high time 20000 -> no lock, err_57=1, duty_err_57=1; at 50% duty -> locks 8.

Source files
------------

// File: rtl/bell_tone_decode_57.sv
// bell_tone_decode_57: recovers the sounding scale note (or silence) from the buzzer square wave.
// Optional macro BELL_TONE_DECODE_DUTY_EN adds a high-time plausibility check and duty_err_57.
module bell_tone_decode_57 #(
  parameter int P_DO        = 190840,
  parameter int P_RE        = 170068,
  parameter int P_MI        = 151515,
  parameter int P_FA        = 143266,
  parameter int P_SO        = 127551,
  parameter int P_LA        = 113636,
  parameter int P_TI        = 101215,
  parameter int P_DOH       = 95602,
  parameter int TOL_SHIFT   = 6,
  parameter int MATCH_N     = 3,
  parameter int SILENCE_CYC = 250000
) (
  input  logic        clk_50m_57,
  input  logic        rst_57,
  input  logic        bell_in_57,
  output logic [3:0]  note_57,
  output logic        note_chg_57,
  output logic [19:0] period_57,
  output logic        err_57
`ifdef BELL_TONE_DECODE_DUTY_EN
  ,
  output logic        duty_err_57
`endif
);

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_ARM  = 2'd1;
  localparam logic [1:0]  ST_MEAS = 2'd2;
  localparam logic [19:0] CNT_MAX = 20'hF_FFFF;
  localparam logic [19:0] SIL_LIM = 20'(SILENCE_CYC);
  localparam logic [3:0]  CLS_UNK = 4'd15;
  localparam logic [3:0]  RUN_MAX = 4'(MATCH_N);

  function automatic int note_period(input int idx);
    case (idx)
      0:       return P_DO;
      1:       return P_RE;
      2:       return P_MI;
      3:       return P_FA;
      4:       return P_SO;
      5:       return P_LA;
      6:       return P_TI;
      default: return P_DOH;
    endcase
  endfunction

  // Windows are disjoint, so at most one note can claim a period; a saturated period is never a note.
  function automatic logic [3:0] classify(input logic [19:0] p);
    logic [3:0]  cls;
    logic [20:0] pw, lo_b, hi_b;
    cls = CLS_UNK;
    pw  = {1'b0, p};
    for (int k = 0; k < 8; k++) begin
      lo_b = 21'(note_period(k) - (note_period(k) >> TOL_SHIFT));
      hi_b = 21'(note_period(k) + (note_period(k) >> TOL_SHIFT));
      if (p != CNT_MAX && pw >= lo_b && pw <= hi_b) cls = 4'(k + 1);
    end
    return cls;
  endfunction

  logic        s1_q, s2_q, s3_q;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  state_q, state_d;
  logic [19:0] period_q, period_d;
  logic [3:0]  cls_q, cls_d;
  logic        cls_vld_q, cls_vld_d;
  logic [3:0]  prev_q, prev_d;
  logic [3:0]  run_q, run_d;
  logic [3:0]  note_q, note_d;
  logic        chg_q, chg_d;
  logic        err_q, err_d;
  logic        rise, silence, go_idle;
  logic [19:0] period_meas;
`ifdef BELL_TONE_DECODE_DUTY_EN
  logic [19:0] hi_q, hi_d;
  logic        duty_bad_q, duty_bad_d;
  logic        duty_err_q, duty_err_d;
  logic [23:0] high_x8, per_x3, per_x5;
  logic        duty_ok;
`endif

  always_comb begin
    rise        = s2_q & ~s3_q;
    period_meas = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 20'd1;
    silence     = (cnt_q >= SIL_LIM);
    cnt_d       = rise ? 20'd0 : period_meas;
`ifdef BELL_TONE_DECODE_DUTY_EN
    // The rise cycle itself is high, hence the restart at one rather than zero.
    hi_d    = rise ? 20'd1 : ((s2_q && hi_q != CNT_MAX) ? hi_q + 20'd1 : hi_q);
    high_x8 = {1'b0, hi_q, 3'b000};
    per_x3  = 24'(period_meas) * 24'd3;
    per_x5  = 24'(period_meas) * 24'd5;
    duty_ok = (high_x8 >= per_x3) && (high_x8 <= per_x5);
`endif
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    cls_d     = cls_q;
    cls_vld_d = 1'b0;
    go_idle   = 1'b0;
`ifdef BELL_TONE_DECODE_DUTY_EN
    duty_bad_d = duty_bad_q;
`endif
    case (state_q)
      ST_IDLE: if (rise) state_d = ST_ARM;
      ST_ARM, ST_MEAS: begin
        if (rise) begin
          state_d   = ST_MEAS;
          period_d  = period_meas;
          cls_vld_d = 1'b1;
          cls_d     = classify(period_meas);
`ifdef BELL_TONE_DECODE_DUTY_EN
          duty_bad_d = ~duty_ok;
          if (!duty_ok) cls_d = CLS_UNK;
`endif
        end else if (silence) begin
          state_d = ST_IDLE;
          go_idle = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lock stage: a note is adopted only after MATCH_N consecutive periods agree; silence breaks the streak.
  always_comb begin
    note_d = note_q;
    chg_d  = 1'b0;
    err_d  = err_q;
    prev_d = prev_q;
    run_d  = run_q;
`ifdef BELL_TONE_DECODE_DUTY_EN
    duty_err_d = duty_err_q;
    if (cls_vld_q && duty_bad_q) duty_err_d = 1'b1;
`endif
    if (go_idle) begin
      run_d  = 4'd0;
      prev_d = 4'd0;
      if (note_q != 4'd0) begin
        note_d = 4'd0;
        chg_d  = 1'b1;
      end
    end else if (cls_vld_q) begin
      if (cls_q == CLS_UNK) begin
        err_d  = 1'b1;
        run_d  = 4'd0;
        prev_d = CLS_UNK;
      end else begin
        if (cls_q == prev_q) begin
          run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 4'd1;
        end else begin
          run_d  = 4'd1;
          prev_d = cls_q;
        end
        if (run_d == RUN_MAX && cls_q != note_q) begin
          note_d = cls_q;
          chg_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_50m_57) begin
    if (!rst_57) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      cnt_q     <= 20'd0;
      state_q   <= ST_IDLE;
      period_q  <= 20'd0;
      cls_q     <= 4'd0;
      cls_vld_q <= 1'b0;
      prev_q    <= 4'd0;
      run_q     <= 4'd0;
      note_q    <= 4'd0;
      chg_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef BELL_TONE_DECODE_DUTY_EN
      hi_q       <= 20'd0;
      duty_bad_q <= 1'b0;
      duty_err_q <= 1'b0;
`endif
    end else begin
      s1_q      <= bell_in_57;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      period_q  <= period_d;
      cls_q     <= cls_d;
      cls_vld_q <= cls_vld_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      note_q    <= note_d;
      chg_q     <= chg_d;
      err_q     <= err_d;
`ifdef BELL_TONE_DECODE_DUTY_EN
      hi_q       <= hi_d;
      duty_bad_q <= duty_bad_d;
      duty_err_q <= duty_err_d;
`endif
    end
  end

  assign note_57     = note_q;
  assign note_chg_57 = chg_q;
  assign period_57   = period_q;
  assign err_57      = err_q;
`ifdef BELL_TONE_DECODE_DUTY_EN
  assign duty_err_57 = duty_err_q;
`endif

endmodule

// File: tb/tb_bell_tone_decode_57.sv
// tb_bell_tone_decode_57: drives scaled-down note periods and compares every cycle against a timing model.
// Note periods and silence time are scaled so the whole run stays short.
module tb_bell_tone_decode_57;

  localparam int P_DO = 954, P_RE = 850, P_MI = 757, P_FA = 716;
  localparam int P_SO = 637, P_LA = 568, P_TI = 506, P_DOH = 478;
  localparam int TOL_SHIFT = 6, MATCH_N = 3, SILENCE_CYC = 1250;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bell = 1'b0;
  logic [3:0]  note;
  logic        chg;
  logic [19:0] period;
  logic        err;
`ifdef BELL_TONE_DECODE_DUTY_EN
  logic        duty_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int note_tab [8] = '{P_DO, P_RE, P_MI, P_FA, P_SO, P_LA, P_TI, P_DOH};

  // Expected rise-detect cycles (pin edge + 2) queued by the stimulus.
  int rise_q [$];
  int hist [$];
  int m_note, m_chg, m_period, m_err;
  int armed, last_rise;
  int pend_valid, pend_at, pend_lock, pend_cls, pend_err;
`ifdef BELL_TONE_DECODE_DUTY_EN
  int high_q [$];
  int last_high, m_duty, pend_duty;
`endif

  bell_tone_decode_57 #(
    .P_DO(P_DO), .P_RE(P_RE), .P_MI(P_MI), .P_FA(P_FA),
    .P_SO(P_SO), .P_LA(P_LA), .P_TI(P_TI), .P_DOH(P_DOH),
    .TOL_SHIFT(TOL_SHIFT), .MATCH_N(MATCH_N), .SILENCE_CYC(SILENCE_CYC)
  ) dut (
    .clk_50m_57  (clk),
    .rst_57      (rst),
    .bell_in_57  (bell),
    .note_57     (note),
    .note_chg_57 (chg),
    .period_57   (period),
    .err_57      (err)
`ifdef BELL_TONE_DECODE_DUTY_EN
    ,
    .duty_err_57 (duty_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, actual, expected);
    end
  endtask

  function automatic int refClass(input int p);
    int diff;
    if (p >= 1048575) return 15;
    for (int k = 0; k < 8; k++) begin
      diff = p - note_tab[k];
      if (diff < 0) diff = -diff;
      if (diff <= (note_tab[k] >> TOL_SHIFT)) return k + 1;
    end
    return 15;
  endfunction

  // Model: outputs react one cycle after a detected rise (period) and two cycles after it (note, err).
  always @(negedge clk) begin
    int p, cls, lock, nxt_chg, is_rise;
    if (!rst) begin
      if (cyc >= 1) begin
        checkOutput("rst_note", 32'(note), 32'd0);
        checkOutput("rst_chg", 32'(chg), 32'd0);
        checkOutput("rst_period", 32'(period), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
      end
      m_note = 0; m_chg = 0; m_period = 0; m_err = 0;
      armed = 0; last_rise = 0; pend_valid = 0;
      hist.delete();
`ifdef BELL_TONE_DECODE_DUTY_EN
      m_duty = 0; last_high = 0;
`endif
    end else begin
      checkOutput("note", 32'(note), 32'(m_note));
      checkOutput("note_chg", 32'(chg), 32'(m_chg));
      checkOutput("period", 32'(period), 32'(m_period));
      checkOutput("err", 32'(err), 32'(m_err));
`ifdef BELL_TONE_DECODE_DUTY_EN
      checkOutput("duty_err", 32'(duty_err), 32'(m_duty));
`endif
      nxt_chg = 0;
      if (pend_valid != 0 && pend_at == cyc + 1) begin
        if (pend_err != 0) m_err = 1;
`ifdef BELL_TONE_DECODE_DUTY_EN
        if (pend_duty != 0) m_duty = 1;
`endif
        if (pend_lock != 0) begin
          m_note = pend_cls;
          nxt_chg = 1;
        end
        pend_valid = 0;
      end
      is_rise = (rise_q.size() > 0 && rise_q[0] == cyc) ? 1 : 0;
      if (is_rise != 0) begin
        void'(rise_q.pop_front());
        if (armed != 0) begin
          p = cyc - last_rise;
          if (p > 1048575) p = 1048575;
          m_period = p;
          cls = refClass(p);
`ifdef BELL_TONE_DECODE_DUTY_EN
          pend_duty = 0;
          if (8 * last_high < 3 * p || 8 * last_high > 5 * p) begin
            cls = 15;
            pend_duty = 1;
          end
`endif
          hist.push_back(cls);
          lock = 0;
          if (cls != 15 && hist.size() >= MATCH_N) begin
            lock = 1;
            for (int j = 0; j < MATCH_N; j++)
              if (hist[hist.size() - 1 - j] != cls) lock = 0;
          end
          if (cls == m_note) lock = 0;
          while (hist.size() > MATCH_N) void'(hist.pop_front());
          pend_valid = 1;
          pend_at    = cyc + 2;
          pend_lock  = lock;
          pend_cls   = cls;
          pend_err   = (cls == 15) ? 1 : 0;
        end
        armed = 1;
        last_rise = cyc;
`ifdef BELL_TONE_DECODE_DUTY_EN
        last_high = high_q.pop_front();
`endif
      end else if (armed != 0 && cyc - last_rise >= SILENCE_CYC + 1) begin
        armed = 0;
        hist.delete();
        if (m_note != 0) begin
          m_note = 0;
          nxt_chg = 1;
        end
      end
      m_chg = nxt_chg;
    end
  end

  // Emits nper pulses of the given period and high time; entered and left just after a clock edge.
  task automatic applyStimulus(input int per, input int high, input int nper);
    for (int i = 0; i < nper; i++) begin
      bell = 1'b1;
      rise_q.push_back(cyc + 2);
`ifdef BELL_TONE_DECODE_DUTY_EN
      high_q.push_back(high);
`endif
      repeat (high) @(posedge clk);
      #1;
      bell = 1'b0;
      repeat (per - high) @(posedge clk);
      #1;
    end
  endtask

  task automatic holdLow(input int n);
    bell = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int k, base, tol, n, sel, per, hi;
    $display("[TB] reset with toggling input");
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      bell = 1'($urandom_range(0, 1));
    end
    rst  = 1'b1;
    bell = 1'b0;
    holdLow(10);

    $display("[TB] la lock, mi lock, switch to fa");
    applyStimulus(P_LA, P_LA / 2, 4);
    applyStimulus(P_MI, P_MI / 2, 4);
    applyStimulus(P_FA, P_FA / 2, 4);

    $display("[TB] tolerance edges around la");
    applyStimulus(P_LA + 8, (P_LA + 8) / 2, 4);
    applyStimulus(P_LA + 9, (P_LA + 9) / 2, 2);
    applyStimulus(P_LA, P_LA / 2, 4);

    $display("[TB] silence after la");
    holdLow(SILENCE_CYC + 30);

`ifdef BELL_TONE_DECODE_DUTY_EN
    $display("[TB] duty window on doh");
    applyStimulus(P_DOH, 100, 4);
    applyStimulus(P_DOH, P_DOH / 2, 5);
    holdLow(SILENCE_CYC + 30);
`endif

    $display("[TB] randomized bursts");
    for (int b = 0; b < 14; b++) begin
      k    = $urandom_range(0, 7);
      base = note_tab[k];
      tol  = base >> TOL_SHIFT;
      n    = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0) per = base + tol + 1 + $urandom_range(0, 20);
        else if (sel == 1) per = $urandom_range(300, 460);
        else per = base - tol + $urandom_range(0, 2 * tol);
        hi = (per * $urandom_range(30, 70)) / 100;
        if (hi < 1) hi = 1;
        if (hi > per - 1) hi = per - 1;
        applyStimulus(per, hi, 1);
      end
      if ($urandom_range(0, 9) < 3) holdLow(SILENCE_CYC + $urandom_range(0, 50));
    end

    holdLow(SILENCE_CYC + 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
